// File: rtl/adder_share_ctrl_pkg.sv
// Shared types and constants for the shared-adder sequencer.
package adder_share_ctrl_pkg;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/adder_share_ctrl_if.sv
// Requester and response channels of the shared-adder sequencer.
interface adder_share_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
);
  logic [N_REQ-1:0]                                    req_valid;
  logic [N_REQ-1:0]                                    req_ready;
  logic [N_REQ-1:0][adder_share_ctrl_pkg::DATA_W-1:0]  req_a;
  logic [N_REQ-1:0][adder_share_ctrl_pkg::DATA_W-1:0]  req_b;
  logic                                                resp_valid;
  logic                                                resp_ready;
  logic [adder_share_ctrl_pkg::DATA_W-1:0]             resp_sum;
  logic [ID_W-1:0]                                     resp_id;
  logic                                                busy;
  logic [CNT_W-1:0]                                    op_count;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_sum, resp_id, busy, op_count
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_sum, resp_id, busy, op_count
  );
endinterface

// File: rtl/_32bit_adder.sv
// Plain 32-bit adder; carry-out is not produced.
module _32bit_adder (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum
);
  assign o_sum = i_a + i_b;
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester above i_ptr wins.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req_valid,
  input  logic [ID_W-1:0]  i_ptr,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_gnt_idx
);
  logic [ID_W-1:0] w_idx;

  // Scan from farthest to nearest so the nearest candidate overwrites the rest.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_idx     = '0;
    if (i_en) begin
      for (int k = N_REQ; k >= 1; k--) begin
        w_idx = ID_W'((int'(i_ptr) + k) % N_REQ);
        if (i_req_valid[w_idx]) begin
          o_gnt        = '0;
          o_gnt[w_idx] = 1'b1;
          o_gnt_idx    = w_idx;
        end
      end
    end
  end
endmodule

// File: rtl/adder_share_ctrl.sv
// Time-multiplexes one 32-bit adder between N_REQ requesters with
// round-robin grant, registered operands and a single response channel.
module adder_share_ctrl
  import adder_share_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  adder_share_ctrl_if.slave bus
);
  state_e           r_state, w_state_nxt;
  logic [ID_W-1:0]  r_ptr, r_id, w_gnt_idx;
  logic [N_REQ-1:0] w_gnt;
  word_t            r_op_a, r_op_b, r_sum, w_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             w_arb_en, w_take, w_done;

  assign w_arb_en = (r_state == S_IDLE);
  assign w_take   = |w_gnt;
  assign w_done   = (r_state == S_RESP) && bus.resp_ready;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .i_req_valid (bus.req_valid),
    .i_ptr       (r_ptr),
    .i_en        (w_arb_en),
    .o_gnt       (w_gnt),
    .o_gnt_idx   (w_gnt_idx)
  );

  _32bit_adder u_add (
    .i_a   (r_op_a),
    .i_b   (r_op_b),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_take) w_state_nxt = S_ADD;
      S_ADD:   w_state_nxt = S_RESP;
      S_RESP:  if (bus.resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pointer starts at N_REQ-1 so requester 0 is searched first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= ID_W'(N_REQ - 1);
      r_id   <= '0;
      r_op_a <= '0;
      r_op_b <= '0;
      r_sum  <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_take) begin
        r_op_a <= bus.req_a[w_gnt_idx];
        r_op_b <= bus.req_b[w_gnt_idx];
        r_id   <= w_gnt_idx;
        r_ptr  <= w_gnt_idx;
      end
      if (r_state == S_ADD) r_sum <= w_sum;
      if (w_done)           r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.req_ready  = w_gnt;
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_sum   = r_sum;
  assign bus.resp_id    = r_id;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.op_count   = r_cnt;
endmodule

// File: doc/adder_share_ctrl.md
# adder_share_ctrl

Sequencer and round-robin arbiter that time-multiplexes one `_32bit_adder` instance between up to N_REQ requesters in the mips32 datapath, such as the PC-increment, branch-target and address-calc users. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, latches its operands and drives the shared adder from registers. It returns the registered sum with the requester ID through a single response channel.

## Interface
- N_REQ, 4: number of requesters (2..8).
- ID_W, 2: width of the requester ID; must satisfy 2^ID_W >= N_REQ.
- CNT_W, 16: width of the completed-operation counter.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester operand-valid.
- req_a  in  N_REQ*32  packed operand A; requester i occupies bits [32*i+31:32*i].
- req_b  in  N_REQ*32  packed operand B, same packing as req_a.
- req_ready  out  N_REQ  one-hot grant; at most one bit high per cycle.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_sum  out  32  (a+b) mod 2^32.
- resp_id  out  ID_W  index of the requester that owns resp_sum.
- busy  out  1  high in every state other than IDLE.
- op_count  out  CNT_W  number of completed responses; wraps.

## Operation
- FSM states:
  - IDLE: if any req_valid bit is set, the arbiter drives req_ready[g] high combinationally. A handshake (req_valid[g] & req_ready[g]) latches op_a, op_b and id=g, and updates the pointer to g. Next state is ADD.
  - ADD: the shared adder sees op_a and op_b from registers. Its output is registered into sum_q. Next state is RESP.
  - RESP: resp_valid=1, resp_sum=sum_q, resp_id=id. On resp_valid & resp_ready, op_count increments and the next state is IDLE. Otherwise the block holds with all outputs stable.
- Arbitration is round-robin. The grant goes to the first requester with req_valid set, searching upward from pointer+1 and wrapping modulo N_REQ.
- After reset the pointer is N_REQ-1, so requester 0 has first priority.
- req_ready is 0 in ADD and RESP. Requesters keep req_valid high while they wait, and their operands must stay stable until the grant.
- req_valid deasserting before the grant is legal; that request is simply not served.
- The adder carry-out is discarded. 0x8000_0000 + 0x8000_0000 yields resp_sum = 0.
- op_count wraps from 2^CNT_W-1 to 0.
- Reset values: state=IDLE, pointer=N_REQ-1, req_ready=0, resp_valid=0, resp_sum=0, resp_id=0, busy=0, op_count=0.
- Reset asserted in ADD or RESP aborts the transaction. No response is issued for it, and the requester must re-request.

## Timing
- A grant handshake in cycle T gives resp_valid high from cycle T+2.
- resp_ready high in cycle T+2 gives state IDLE in T+3, and the next grant is possible in T+3.
- Peak throughput is one operation per 3 cycles.
- resp_ready high before resp_valid has no effect.
- A new request arriving in the same cycle as a response handshake is not granted until the following IDLE cycle.
- busy rises in the cycle after the grant handshake and falls in the cycle after the response handshake.

## Structure
- Shared header adder_ctrl_defs.vh holds:
  - the state encodings S_IDLE=2'd0, S_ADD=2'd1, S_RESP=2'd2;
  - the data width constant 32;
  - the testbench `DELAY.
- Sub-module rr_arbiter (parameters N_REQ, ID_W) takes req_valid, pointer and enable, and returns the one-hot grant and its encoded index. It is purely combinational.
- The pointer register stays in adder_share_ctrl.
- Exactly one `_32bit_adder` is instantiated; its inputs come from op_a and op_b.

## Test plan
- Single request, with resp_ready held high:
  - Stimulus: req_valid=4'b0001, a=0x0000_0010, b=0x0000_0009.
  - Required: req_ready=4'b0001 in T; resp_valid high in T+2 with resp_sum=0x0000_0019 and resp_id=0; op_count=1.
- All four requesters valid continuously, with distinct operands:
  - Required: grants occur in order 0,1,2,3,0.
  - Required: each grant is 3 cycles after the previous one, and each resp_sum matches its requester's operands.
- Overflow:
  - Stimulus: a=0x8000_0000, b=0x8000_0000.
  - Required: resp_sum=0x0000_0000. Separately, a=0x4000_0000, b=0x4000_0001 gives 0x8000_0001.
- Consumer backpressure:
  - Stimulus: hold resp_ready=0 for 5 cycles.
  - Required: resp_valid, resp_sum and resp_id remain stable; req_ready stays 0 throughout; the response completes on the first cycle with resp_ready=1.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during ADD.
  - Required: all outputs return to reset values immediately (asynchronously); no resp_valid follows; op_count=0; the next grant goes to requester 0.
- Counter wrap:
  - Stimulus: CNT_W=2, perform 5 operations.
  - Required: op_count sequence is 1,2,3,0,1.
